// File: rtl/op_issuer_if.sv
// Host-side handshake bundle for op_issuer: command, write-data and read-data channels.
// The host drives through the master modport; the issuer uses the slave modport.
interface op_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/op_issuer.sv
// op_issuer: turns host command words into the cycle-exact operation/in_data
// sequences the matrix controller expects, and collects its read-back data.
// Page writes are staged in a local buffer before an unstalled burst. Page reads
// are captured into the same buffer and then drained to the host.
module op_issuer #(
  parameter int PAGE_WORDS = 64,
  parameter int MM_CYCLES  = 136,
  parameter int GAP_CYCLES = 2,
  parameter int RD_LAT     = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  op_issuer_if.slave  bus,
  output logic [31:0] o_operation,
  output logic [31:0] o_in_data,
  input  logic [31:0] i_out_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int AW    = $clog2(PAGE_WORDS);
  localparam int CW_PG = AW + 1;
  localparam int CW_MM = $clog2(MM_CYCLES + 1);
  localparam int CW_GP = $clog2(GAP_CYCLES + 1);
  localparam int CW_A  = (CW_PG > CW_MM) ? CW_PG : CW_MM;
  localparam int CW    = (CW_A > CW_GP) ? CW_A : CW_GP;

  // One shared counter serves every state; the read path keeps counting through
  // RWAIT so the capture index is simply cnt - RD_LAT.
  localparam logic [CW-1:0] C_PG_LAST  = CW'(PAGE_WORDS - 1);
  localparam logic [CW-1:0] C_MM_LAST  = CW'(MM_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] C_RW_LAST  = CW'(PAGE_WORDS + RD_LAT - 1);
  localparam logic [CW-1:0] C_RD_LAT   = CW'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WBURST, S_MM, S_RBURST, S_RWAIT, S_DRAIN, S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [31:0]     r_op_q;
  logic [31:0]     w_op_next;
  logic [31:0]     r_buf [PAGE_WORDS];
  logic [31:0]     r_operation;
  logic [31:0]     r_in_data;
  logic [31:0]     r_rd_data;
  logic            r_done;
  logic            r_err;
  logic            w_done_next;
  logic            w_err_next;
  logic            w_cmd_ready;
  logic            w_wr_ready;
  logic            w_rd_valid;
  logic            w_accept;
  logic            w_wr_hs;
  logic            w_rd_hs;
  logic            w_issue_next;
  logic            w_cap_en;
  logic [AW-1:0]   w_cap_idx;
  logic [AW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_wr_idx;

  // Handshake readiness is gated by enable so nothing completes while frozen.
  assign w_cmd_ready = (r_state == S_IDLE) && i_enable;
  assign w_wr_ready  = (r_state == S_FILL) && i_enable;
  assign w_rd_valid  = (r_state == S_DRAIN) && i_enable;
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_wr_hs     = bus.wr_valid && w_wr_ready;
  assign w_rd_hs     = w_rd_valid && bus.rd_ready;

  // The opcode word takes effect on the very edge it is accepted so MM starts next cycle.
  assign w_op_next    = w_accept ? bus.cmd_op : r_op_q;
  assign w_issue_next = (w_state_next == S_WBURST) || (w_state_next == S_MM) ||
                        (w_state_next == S_RBURST);
  assign w_cap_en     = ((r_state == S_RBURST) || (r_state == S_RWAIT)) && (r_cnt >= C_RD_LAT);
  assign w_cap_idx    = AW'(r_cnt - C_RD_LAT);
  assign w_rd_idx     = w_cnt_next[AW-1:0];
  assign w_wr_idx     = r_cnt[AW-1:0];

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign o_operation   = r_operation;
  assign o_in_data     = r_in_data;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;

  // Next-state, next-count and status decode for the command sequencer.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_err_next   = r_err;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = {CW{1'b0}};
        if (w_accept) begin
          case (bus.cmd_op[3:0])
            4'd0:    w_done_next  = 1'b1;
            4'd1:    w_state_next = S_MM;
            4'd2:    w_state_next = S_FILL;
            4'd3:    w_state_next = S_RBURST;
            default: w_err_next   = 1'b1;
          endcase
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_wr_hs && (r_cnt == C_PG_LAST)) begin
          w_state_next = S_WBURST;
          w_cnt_next   = {CW{1'b0}};
        end else if (w_wr_hs) begin
          w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      S_WBURST: begin
        if (r_cnt == C_PG_LAST) begin
          w_state_next = S_GAP;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_MM: begin
        if (r_cnt == C_MM_LAST) begin
          w_state_next = S_GAP;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_RBURST: begin
        w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        if (r_cnt == C_PG_LAST) begin
          w_state_next = S_RWAIT;
        end else begin
          w_state_next = S_RBURST;
        end
      end
      S_RWAIT: begin
        if (r_cnt == C_RW_LAST) begin
          w_state_next = S_DRAIN;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        if (w_rd_hs && (r_cnt == C_PG_LAST)) begin
          w_state_next = S_GAP;
          w_cnt_next   = {CW{1'b0}};
        end else if (w_rd_hs) begin
          w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      S_GAP: begin
        if (r_cnt == C_GAP_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = {CW{1'b0}};
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = {CW{1'b0}};
      end
    endcase
  end

  // Sequencer state plus registered controller/host outputs, all frozen while enable is low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_op_q      <= 32'h0;
      r_operation <= 32'h0;
      r_in_data   <= 32'h0;
      r_rd_data   <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_enable) begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_op_q      <= w_op_next;
      r_operation <= w_issue_next ? w_op_next : 32'h0;
      r_in_data   <= (w_state_next == S_WBURST) ? r_buf[w_rd_idx] : 32'h0;
      r_rd_data   <= (w_state_next == S_DRAIN) ? r_buf[w_rd_idx] : 32'h0;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
    end
  end

  // Page buffer: filled by host writes in FILL or by controller read-back captures.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_enable) begin
      if (w_wr_hs) begin
        r_buf[w_wr_idx] <= bus.wr_data;
      end else if (w_cap_en) begin
        r_buf[w_cap_idx] <= i_out_data;
      end
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// Self-checking bench for op_issuer with a small page (4 words) and a short matmul (5 cycles).
module tb_op_issuer;
  localparam int PW = 4;
  localparam int MM = 5;
  localparam int GP = 2;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] operation;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        err;
  int          rd_k;
  int          n_checks = 0;
  int          n_pass = 0;

  op_issuer_if bus();

  op_issuer #(.PAGE_WORDS(PW), .MM_CYCLES(MM), .GAP_CYCLES(GP), .RD_LAT(RL)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .bus(bus),
    .o_operation(operation), .o_in_data(in_data), .i_out_data(out_data),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // Controller read model: returns 0x100+k one cycle after read word k is presented.
  always @(posedge clk) begin
    if (reset) begin
      out_data <= 32'h0;
      rd_k     <= 0;
    end else if (enable) begin
      if (operation == 32'h3) begin
        out_data <= 32'h100 + 32'(rd_k);
        rd_k     <= rd_k + 1;
      end else begin
        rd_k <= 0;
      end
    end
  end

  typedef struct {
    logic        cv;
    logic [31:0] cop;
    logic        wv;
    logic [31:0] wd;
    logic [31:0] eop;
    logic [31:0] ein;
    logic        edone;
    logic        ewr;
  } vec_t;

  vec_t vec[29];

  function automatic vec_t mk(logic cv, logic [31:0] cop, logic wv, logic [31:0] wd,
                              logic [31:0] eop, logic [31:0] ein, logic edone, logic ewr);
    vec_t v;
    v.cv = cv; v.cop = cop; v.wv = wv; v.wd = wd;
    v.eop = eop; v.ein = ein; v.edone = edone; v.ewr = ewr;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cnt;
    int found;
    logic [31:0] K;
    logic [31:0] M;
    K = 32'h12;
    M = 32'h1001;

    // write burst, then two back-to-back matmuls with the command held valid
    vec[0]  = mk(1'b1, K, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    vec[1]  = mk(1'b0, 32'h0, 1'b1, 32'hA, 32'h0, 32'h0, 1'b0, 1'b1);
    vec[2]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    vec[3]  = mk(1'b0, 32'h0, 1'b1, 32'hB, 32'h0, 32'h0, 1'b0, 1'b1);
    vec[4]  = mk(1'b0, 32'h0, 1'b1, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1);
    vec[5]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    vec[6]  = mk(1'b0, 32'h0, 1'b1, 32'hD, K, 32'hA, 1'b0, 1'b0);
    vec[7]  = mk(1'b0, 32'h0, 1'b0, 32'h0, K, 32'hB, 1'b0, 1'b0);
    vec[8]  = mk(1'b0, 32'h0, 1'b0, 32'h0, K, 32'hC, 1'b0, 1'b0);
    vec[9]  = mk(1'b0, 32'h0, 1'b0, 32'h0, K, 32'hD, 1'b0, 1'b0);
    vec[10] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vec[11] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vec[12] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vec[13] = mk(1'b1, M, 1'b0, 32'h0, M, 32'h0, 1'b0, 1'b0);
    for (int i = 14; i < 18; i++) vec[i] = mk(1'b0, 32'h0, 1'b0, 32'h0, M, 32'h0, 1'b0, 1'b0);
    vec[18] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vec[19] = mk(1'b1, M, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vec[20] = mk(1'b1, M, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vec[21] = mk(1'b1, M, 1'b0, 32'h0, M, 32'h0, 1'b0, 1'b0);
    for (int i = 22; i < 26; i++) vec[i] = mk(1'b0, 32'h0, 1'b0, 32'h0, M, 32'h0, 1'b0, 1'b0);
    vec[26] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vec[27] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vec[28] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    reset = 1'b1; enable = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 32'h0;
    bus.wr_valid = 1'b0; bus.wr_data = 32'h0; bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check32("rst_operation", operation, 32'h0);
    check32("rst_in_data", in_data, 32'h0);
    check1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check1("rst_wr_ready", bus.wr_ready, 1'b0);
    check1("rst_rd_valid", bus.rd_valid, 1'b0);
    check32("rst_rd_data", bus.rd_data, 32'h0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_busy", busy, 1'b0);

    // table: page write and matmul sequences
    for (int i = 0; i < 29; i++) begin
      bus.cmd_valid = vec[i].cv; bus.cmd_op = vec[i].cop;
      bus.wr_valid = vec[i].wv; bus.wr_data = vec[i].wd;
      tick();
      check32($sformatf("vec%0d_operation", i), operation, vec[i].eop);
      check32($sformatf("vec%0d_in_data", i), in_data, vec[i].ein);
      check1($sformatf("vec%0d_done", i), done, vec[i].edone);
      check1($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vec[i].ewr);
    end
    bus.cmd_valid = 1'b0; bus.cmd_op = 32'h0; bus.wr_valid = 1'b0; bus.wr_data = 32'h0;

    // page read: capture and drain with rd_ready toggling
    bus.cmd_valid = 1'b1; bus.cmd_op = 32'h3;
    tick();
    bus.cmd_valid = 1'b0;
    cnt = 0; found = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rd_valid) begin found = 1; break; end
      if (operation == 32'h3) cnt++;
      tick();
    end
    check1("rd_valid_seen", found == 1, 1'b1);
    check32("rd_issue_cycles", 32'(cnt), 32'(PW));
    n = 0;
    for (int i = 0; i < 40 && n < PW; i++) begin
      bus.rd_ready = (i % 2 == 0);
      if (bus.rd_valid) begin
        check32($sformatf("rd_data_%0d", i), bus.rd_data, 32'h100 + 32'(n));
        if (bus.rd_ready) n++;
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    check32("rd_word_count", 32'(n), 32'(PW));
    check1("rd_valid_after_drain", bus.rd_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin found = 1; break; end
      tick();
    end
    check1("rd_done_seen", found == 1, 1'b1);

    // unsupported opcode sets sticky err, then a nop still completes
    bus.cmd_valid = 1'b1; bus.cmd_op = 32'h7;
    tick();
    bus.cmd_valid = 1'b0;
    check1("bad_err", err, 1'b1);
    check1("bad_done", done, 1'b0);
    check32("bad_operation", operation, 32'h0);
    check1("bad_cmd_ready", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 32'h0;
    tick();
    bus.cmd_valid = 1'b0;
    check1("nop_done", done, 1'b1);
    check1("nop_err_sticky", err, 1'b1);

    // matmul with enable dropped for three cycles
    bus.cmd_valid = 1'b1; bus.cmd_op = M;
    tick();
    bus.cmd_valid = 1'b0;
    cnt = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      enable = !(i >= 2 && i < 5);
      if (!enable) check32($sformatf("mm_hold_%0d", i), operation, M);
      if (enable && operation == M) cnt++;
      if (enable && done) begin found = 1; break; end
      tick();
    end
    enable = 1'b1;
    check1("mm_en_done", found == 1, 1'b1);
    check32("mm_en_high_cycles", 32'(cnt), 32'(MM));

    // reset in the middle of a write burst (word 2)
    bus.cmd_valid = 1'b1; bus.cmd_op = K;
    tick();
    bus.cmd_valid = 1'b0;
    for (int j = 0; j < PW; j++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 32'h21 + 32'(j);
      tick();
    end
    bus.wr_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (operation == K && in_data == 32'h23) begin found = 1; break; end
      tick();
    end
    check1("wb_word2_seen", found == 1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check32("abort_operation", operation, 32'h0);
    check32("abort_in_data", in_data, 32'h0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check1("abort_done", done, 1'b0);
    check1("abort_err_cleared", err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check1($sformatf("abort_no_done_%0d", i), done, 1'b0);
      check32($sformatf("abort_op_idle_%0d", i), operation, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/op_issuer.md
Name: op_issuer

Overview:
- Host-side initiator that drives the matrix controller's `operation`/`in_data` inputs and collects its `out_data`.
- Accepts one command word at a time from the host and converts it into the cycle-exact sequence the controller requires:
  - page serial-write (opcode 2), streamed from an internal page buffer;
  - matmul (opcode 1), held for a fixed duration followed by an idle gap;
  - page serial-read (opcode 3), captured into the page buffer and then drained to the host.
- Shares `clk`, `enable` and `reset` with the controller.

Parameters:
- PAGE_WORDS, 64: words per page serial transfer (power of 2, 2..256).
- MM_CYCLES, 136: cycles opcode 1 is held asserted for a matmul.
- GAP_CYCLES, 2: idle cycles (operation=0) after every command, ≥1.
- RD_LAT, 1: cycles from presenting read word k to out_data valid for word k.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  global enable; all state and outputs frozen when low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  issuer can accept command
- cmd_op  in  32  operation word; [3:0] opcode, remaining fields passed through unchanged
- wr_valid  in  1  host write-data valid
- wr_ready  out  1  issuer accepting write data
- wr_data  in  32  write-data word
- rd_valid  out  1  read-data valid
- rd_ready  in  1  host accepts read data
- rd_data  out  32  read-data word
- operation  out  32  to controller operation input (registered)
- in_data  out  32  to controller in_data input (registered)
- out_data  in  32  from controller out_data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE after a non-error command
- err  out  1  sticky; set on unsupported opcode, cleared only by reset

Behaviour:
- Reset (synchronous, active-high, dominates enable):
  - state=IDLE; operation=0; in_data=0; counters=0.
  - cmd_ready=1 (after reset deasserts); wr_ready=0; rd_valid=0; rd_data=0; done=0; err=0.
  - Buffer contents are don't-care.
- enable=0: no register changes; handshakes do not complete (cmd_ready, wr_ready and rd_valid are gated by enable).
- Command latch: cmd_op is latched into op_q on cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE.
- State transitions:
  - IDLE, accepted opcode 0 → done pulse next cycle, stay IDLE.
  - IDLE, accepted opcode 1 → MM.
  - IDLE, accepted opcode 2 → FILL.
  - IDLE, accepted opcode 3 → RBURST.
  - IDLE, accepted opcode 4..15 → err set, stay IDLE, no done.
- FILL:
  - wr_ready=1.
  - Each wr handshake writes buf[cnt], cnt++.
  - On handshake with cnt==PAGE_WORDS-1: cnt←0, go to WBURST.
  - operation stays 0 throughout.
- WBURST:
  - For exactly PAGE_WORDS consecutive cycles: operation=op_q and in_data=buf[k] for k=0..PAGE_WORDS-1 in order.
  - No stalls permitted.
  - Then go to GAP.
- MM:
  - operation=op_q for exactly MM_CYCLES consecutive cycles, then GAP.
  - The controller detects the opcode-1 rising edge, so GAP guarantees a 0 between back-to-back matmuls.
- RBURST:
  - operation=op_q for exactly PAGE_WORDS cycles.
  - The word presented in issue cycle k (k=0..PAGE_WORDS-1) is captured from out_data RD_LAT cycles later into buf[k].
  - Capture continues through the first RD_LAT cycles after RBURST, with operation=0 during those cycles (state RWAIT).
  - Then go to DRAIN.
- DRAIN:
  - rd_valid=1, rd_data=buf[idx]; idx advances on rd_ready.
  - rd_data is held stable while rd_valid&&!rd_ready.
  - After the handshake of idx==PAGE_WORDS-1 → GAP.
- GAP: operation=0 for GAP_CYCLES cycles, then IDLE with a done pulse in the first IDLE cycle.
- Registered outputs: operation and in_data are registered. The first burst cycle is the cycle after the state-entry edge; no combinational path from cmd_* to operation.
- in_data=0 in every state except WBURST.
- Reset mid-operation: aborts immediately. operation=0 in the cycle after reset is sampled. No partial rd_valid and no done.
- Counters are $clog2(PAGE_WORDS)+1 bits wide; MM/GAP counters are wide enough for their parameters. No wrap-around inside a burst.

Test Plan:
1. PAGE_WORDS=4. cmd 0x00000012, then wr words 0xA,0xB,0xC,0xD with wr_valid gaps → exactly 4 contiguous cycles of operation=0x12 with in_data A,B,C,D. Then 2 cycles of operation=0, then a done pulse.
2. cmd 0x00001001 (MM_CYCLES=5) → operation=0x1001 for 5 cycles, 0 for 2 cycles, done. An immediately repeated identical cmd shows at least 2 zero cycles between the two high runs.
3. PAGE_WORDS=4, RD_LAT=1, model returns out_data=0x100+k one cycle after read word k → rd_data sequence 0x100..0x103. With rd_ready toggled 1,0,1,0…, every word appears exactly once and is held while stalled.
4. cmd opcode 7 → err=1, no done, operation stays 0, cmd_ready stays 1. The next valid cmd executes normally and err remains 1.
5. Reset asserted in the middle of WBURST (word 2) → next cycle operation=0, in_data=0, state IDLE, cmd_ready=1, no done.
6. enable=0 for 3 cycles during MM → operation is held, and the total count of high cycles with enable=1 still equals MM_CYCLES.
